// File: rtl/tick_monitor_pkg.sv
// Shared types for the tick strobe checker: FSM states, per-cycle event codes
// and the saturating error-count helper.
package tick_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_GOOD  = 2'd1,
    EV_EARLY = 2'd2,
    EV_MISS  = 2'd3
  } event_e;

  localparam int unsigned ERR_W = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tick_interval_cnt.sv
// Saturating interval counter: load-1 on tick, hold or increment otherwise,
// with an equality flag at the timeout value.
module tick_interval_cnt
  import tick_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 20,
  parameter int unsigned LIMIT = 1001001
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (!hold_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/tick_monitor.sv
// Receive-side checker for a periodic single-cycle tick: measures intervals,
// locks after LOCK_COUNT good intervals, and flags early or missing ticks.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned NOM_PERIOD = 1000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_clear,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_early,
  output logic             o_miss,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned TIMEOUT   = NOM_PERIOD + TOL + 1;
  localparam int unsigned EARLY_LIM = (TOL >= NOM_PERIOD) ? 0 : NOM_PERIOD - TOL;
  localparam int unsigned GOOD_W    = $clog2(LOCK_COUNT + 1);

  if ((64'(NOM_PERIOD) + 64'(TOL) + 64'd1) >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
    $error("tick_monitor: CNT_W too narrow for NOM_PERIOD+TOL+1");
  end
  if (LOCK_COUNT < 1) begin : g_lock_chk
    $error("tick_monitor: LOCK_COUNT must be at least 1");
  end

  state_e             state_q;
  logic [GOOD_W-1:0]  good_q;
  logic [CNT_W-1:0]   period_q;
  logic               vld_q, early_q, miss_q;
  logic [ERR_W-1:0]   err_q;

  logic [CNT_W-1:0]   cnt;
  logic               at_limit;
  logic               tracking;
  event_e             ev;

  tick_interval_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_cnt (
    .clk_i      (i_clk),
    .rst_n_i    (i_rst_n),
    .load_i     (i_tick),
    .hold_i     (state_q == LOST),
    .cnt_o      (cnt),
    .at_limit_o (at_limit)
  );

  assign tracking = (state_q == ACQUIRE) || (state_q == LOCKED);

  // Timeout wins over a coincident tick; any tick that is not early or a
  // timeout is necessarily in-window, as the counter restarts on every tick.
  always_comb begin
    ev = EV_NONE;
    if (tracking) begin
      if (at_limit) begin
        ev = EV_MISS;
      end else if (i_tick) begin
        ev = (cnt < CNT_W'(EARLY_LIM)) ? EV_EARLY : EV_GOOD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      early_q  <= 1'b0;
      miss_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      vld_q   <= 1'b0;
      early_q <= 1'b0;
      miss_q  <= 1'b0;
      if (i_clear) begin
        state_q <= SEARCH;
        good_q  <= '0;
        err_q   <= '0;
      end else begin
        if ((ev == EV_EARLY) || (ev == EV_MISS)) begin
          err_q <= sat_inc(err_q);
        end
        if ((ev == EV_GOOD) || (ev == EV_EARLY)) begin
          period_q <= cnt;
          vld_q    <= 1'b1;
        end
        early_q <= (ev == EV_EARLY);
        miss_q  <= (ev == EV_MISS);
        case (state_q)
          SEARCH, LOST: begin
            if (i_tick) begin
              state_q <= ACQUIRE;
              good_q  <= '0;
            end
          end
          ACQUIRE, LOCKED: begin
            case (ev)
              EV_MISS: begin
                good_q  <= '0;
                state_q <= i_tick ? ACQUIRE : ((state_q == ACQUIRE) ? SEARCH : LOST);
              end
              EV_EARLY: begin
                good_q  <= '0;
                state_q <= ACQUIRE;
              end
              EV_GOOD: begin
                if (state_q == ACQUIRE) begin
                  good_q <= good_q + 1'b1;
                  if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                    state_q <= LOCKED;
                  end
                end
              end
              default: ;
            endcase
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign o_locked     = (state_q == LOCKED);
  assign o_period     = period_q;
  assign o_period_vld = vld_q;
  assign o_early      = early_q;
  assign o_miss       = miss_q;
  assign o_err_cnt    = err_q;

endmodule
